// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths, opcodes and FSM encoding for the hazard controller
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int OPC_W = 6;
    localparam int CNT_W = 16;

    localparam logic [OPC_W-1:0] OPC_BEQ = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE = 6'h05;
    localparam logic [OPC_W-1:0] OPC_J   = 6'h02;
    localparam logic [OPC_W-1:0] OPC_LW  = 6'h23;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_BR_STALL = 3'd2,
        ST_MEM_WAIT = 3'd3
    } state_t;

    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BNE);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/EX/memory inputs and pipeline control outputs of the hazard controller
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [OPC_W-1:0] id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             ex_regwrite;
    logic [REG_W-1:0] ex_rd;
    logic             br_taken;
    logic             imem_ready;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_hold;
    logic [2:0]       state_o;

    modport master (
        output id_opcode, id_rs, id_rt, ex_memread, ex_rt, ex_regwrite, ex_rd,
               br_taken, imem_ready, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, state_o
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_memread, ex_rt, ex_regwrite, ex_rd,
               br_taken, imem_ready, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, state_o
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - combinational load-use / load-to-branch / ALU-to-branch hazard terms
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu,
    output logic             bh,
    output logic             is_br
);

    // $zero is hard-wired, so a producer targeting it never blocks a consumer
    assign is_br = is_branch(id_opcode);
    assign lu    = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign bh    = is_br && ex_regwrite && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard FSM; HAZARD_CTRL_PERF_EN adds stall/flush counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hazard_ctrl_if.slave         bus
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    state_t state, state_nxt;
    logic   lu, bh, is_br;
    logic   pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;

    hazard_detect u_detect (
        .id_opcode   (bus.id_opcode),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_memread  (bus.ex_memread),
        .ex_rt       (bus.ex_rt),
        .ex_regwrite (bus.ex_regwrite),
        .ex_rd       (bus.ex_rd),
        .lu          (lu),
        .bh          (bh),
        .is_br       (is_br)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        if (!rst) begin
            // reset acts immediately on the outputs, not just on the next edge
            state_nxt   = ST_RUN;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!bus.dmem_ready) begin
                        exmem_hold = 1'b1;
                        state_nxt  = ST_MEM_WAIT;
                    end else if (lu || bh) begin
                        idex_bubble = 1'b1;
                        state_nxt   = (lu && is_br) ? ST_BR_STALL : ST_LU_STALL;
                    end else if (bus.br_taken || (bus.id_opcode == OPC_J)) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (!bus.imem_ready) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_nxt  = ST_RUN;
                end
                ST_BR_STALL: begin
                    idex_bubble = 1'b1;
                    state_nxt   = ST_LU_STALL;
                end
                ST_MEM_WAIT: begin
                    // ID stays frozen on the release cycle; RUN re-evaluates hazards next
                    exmem_hold = !bus.dmem_ready;
                    if (bus.dmem_ready) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_hold  = exmem_hold;
    assign bus.state_o     = state;

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
